// File: rtl/uart_tx_arb_pkg.sv
// Shared types for the UART transmit-side arbiter: FSM encoding and
// watchdog counter width.
package uart_tx_arb_pkg;

  localparam int STALL_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HDR    = 2'd1,
    ST_STREAM = 2'd2
  } state_t;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmitter-FIFO bundle seen by uart_tx_arbiter.
// A requester byte transfers on a clk_main edge where req_valid[i] & req_ready[i];
// valid may not depend on ready, and ready is only ever raised for the current owner.
interface uart_tx_arbiter_if
  import uart_tx_arb_pkg::*;
#(
  parameter int N_REQ = 4
) ();

  logic [N_REQ-1:0]   req_valid;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_last;
  logic [N_REQ-1:0]   req_ready;
  logic               tf_full;
  logic               fifo_wr;
  logic [7:0]         tf_in;
  logic [N_REQ-1:0]   grant;
  logic               abort;
  state_t             state_dbg;

  modport slave (
    input  req_valid, req_data, req_last, tf_full,
    output req_ready, fifo_wr, tf_in, grant, abort, state_dbg
  );

  modport master (
    output req_valid, req_data, req_last, tf_full,
    input  req_ready, fifo_wr, tf_in, grant, abort, state_dbg
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first set request found
// searching upward (wrapping) from last_idx+1.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_idx,
  output logic             any,
  output logic [IDX_W-1:0] gidx,
  output logic [N-1:0]     onehot
);

  always_comb begin
    int               idx;
    logic [IDX_W-1:0] idx_v;
    any    = 1'b0;
    gidx   = '0;
    onehot = '0;
    idx    = 0;
    idx_v  = '0;
    for (int k = 1; k <= N; k++) begin
      idx   = (int'(last_idx) + k) % N;
      idx_v = IDX_W'(idx);
      if (!any && req[idx_v]) begin
        any           = 1'b1;
        gidx          = idx_v;
        onehot[idx_v] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing the UART TX FIFO write port among N_REQ
// byte-stream requesters, with optional source header and stall watchdog.
module uart_tx_arbiter
  import uart_tx_arb_pkg::*;
#(
  parameter int         N_REQ     = 4,
  parameter bit         HDR_EN    = 1'b1,
  parameter logic [7:0] HDR_BASE  = 8'hA0,
  parameter int         STALL_MAX = 255
) (
  input logic              clk_main,
  input logic              rst_main,
  uart_tx_arbiter_if.slave bus
);

  localparam int                   IDX_W     = $clog2(N_REQ);
  localparam logic [IDX_W-1:0]     LAST_RST  = IDX_W'(N_REQ - 1);
  localparam logic [STALL_W-1:0]   STALL_LIM = STALL_W'(STALL_MAX);

  state_t             state_q, state_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]   gidx_q, gidx_d;
  logic [IDX_W-1:0]   last_idx_q, last_idx_d;
  logic [STALL_W-1:0] stall_q, stall_d;

  logic               pick_any;
  logic [IDX_W-1:0]   pick_idx;
  logic [N_REQ-1:0]   pick_oh;

  logic               own_valid;
  logic               own_last;
  logic [7:0]         own_data;
  logic [7:0]         hdr_byte;
  logic [STALL_W-1:0] stall_inc;

  logic               fifo_wr;
  logic [7:0]         tf_in;
  logic [N_REQ-1:0]   req_ready;
  logic               abort;

  rr_pick #(.N(N_REQ), .IDX_W(IDX_W)) u_pick (
    .req      (bus.req_valid),
    .last_idx (last_idx_q),
    .any      (pick_any),
    .gidx     (pick_idx),
    .onehot   (pick_oh)
  );

  assign own_valid = bus.req_valid[gidx_q];
  assign own_last  = bus.req_last[gidx_q];
  assign own_data  = bus.req_data[{gidx_q, 3'b000} +: 8];
  assign hdr_byte  = HDR_BASE + 8'(gidx_q);
  assign stall_inc = stall_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    gidx_d     = gidx_q;
    last_idx_d = last_idx_q;
    stall_d    = stall_q;
    fifo_wr    = 1'b0;
    tf_in      = 8'h00;
    req_ready  = '0;
    abort      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        stall_d = '0;
        if (pick_any) begin
          grant_d = pick_oh;
          gidx_d  = pick_idx;
          state_d = HDR_EN ? ST_HDR : ST_STREAM;
        end
      end
      ST_HDR: begin
        stall_d = '0;
        if (!bus.tf_full) begin
          fifo_wr = 1'b1;
          tf_in   = hdr_byte;
          state_d = ST_STREAM;
        end
      end
      ST_STREAM: begin
        req_ready[gidx_q] = ~bus.tf_full;
        // A full FIFO freezes the watchdog: that stall is not the owner's fault.
        if (!bus.tf_full) begin
          if (own_valid) begin
            fifo_wr = 1'b1;
            tf_in   = own_data;
            stall_d = '0;
            if (own_last) begin
              last_idx_d = gidx_q;
              grant_d    = '0;
              state_d    = ST_IDLE;
            end
          end else if (stall_inc == STALL_LIM) begin
            abort      = 1'b1;
            last_idx_d = gidx_q;
            grant_d    = '0;
            stall_d    = '0;
            state_d    = ST_IDLE;
          end else begin
            stall_d = stall_inc;
          end
        end
      end
      default: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_main or posedge rst_main) begin
    if (rst_main) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      gidx_q     <= '0;
      last_idx_q <= LAST_RST;
      stall_q    <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      gidx_q     <= gidx_d;
      last_idx_q <= last_idx_d;
      stall_q    <= stall_d;
    end
  end

  assign bus.fifo_wr   = fifo_wr;
  assign bus.tf_in     = tf_in;
  assign bus.req_ready = req_ready;
  assign bus.abort     = abort;
  assign bus.grant     = grant_q;
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: per-requester byte queues drive the
// inputs, an in-order expected queue checks every FIFO write.
module tb_uart_tx_arbiter;
  import uart_tx_arb_pkg::*;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.N_REQ(N)) bus ();

  uart_tx_arbiter #(
    .N_REQ     (N),
    .HDR_EN    (1'b1),
    .HDR_BASE  (8'hA0),
    .STALL_MAX (4)
  ) dut (
    .clk_main (clk),
    .rst_main (rst),
    .bus      (bus)
  );

  logic [8:0]   rq [N][$];
  logic [7:0]   exp_q[$];
  int           wr_cyc[$];
  int           abort_cyc[$];
  int           cyc;
  int           n_checks;
  int           n_pass;
  int           t0;
  logic [N-1:0] acc;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %0h, want %0h (cycle %0d)", tag, obs, exp, cyc);
    else n_pass++;
  endtask

  // ---------------- drivers ----------------
  task automatic drive_inputs();
    logic [N-1:0]   v;
    logic [N-1:0]   l;
    logic [8*N-1:0] d;
    logic [8:0]     e;
    v = '0;
    l = '0;
    d = '0;
    for (int i = 0; i < N; i++) begin
      if (rq[i].size() > 0) begin
        e          = rq[i][0];
        v[i]       = 1'b1;
        l[i]       = e[8];
        d[i*8 +: 8] = e[7:0];
      end
    end
    bus.req_valid = v;
    bus.req_last  = l;
    bus.req_data  = d;
  endtask

  task automatic push_byte(input int r, input logic [7:0] b, input logic last);
    rq[r].push_back({last, b});
  endtask

  // One clock: observe at negedge, then update requesters after the edge.
  task automatic step();
    logic [7:0] e;
    @(negedge clk);
    acc = bus.req_ready & bus.req_valid;
    if (bus.fifo_wr) begin
      wr_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("sb_extra_wr", 32'(bus.tf_in), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("sb_byte", 32'(bus.tf_in), 32'(e));
      end
    end
    if (bus.tf_full) check("no_wr_when_full", 32'(bus.fifo_wr), 32'd0);
    if (bus.abort) abort_cyc.push_back(cyc);
    @(posedge clk);
    cyc++;
    #1;
    for (int i = 0; i < N; i++)
      if (acc[i] && rq[i].size() > 0) void'(rq[i].pop_front());
    drive_inputs();
  endtask

  task automatic run_drain(input string tag, input int max_cyc);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max_cyc) begin
      step();
      n++;
    end
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_grant"},   32'(bus.grant),     32'd0);
    check({tag, "_fifo_wr"}, 32'(bus.fifo_wr),   32'd0);
    check({tag, "_tf_in"},   32'(bus.tf_in),     32'd0);
    check({tag, "_ready"},   32'(bus.req_ready), 32'd0);
    check({tag, "_abort"},   32'(bus.abort),     32'd0);
    check({tag, "_state"},   32'(bus.state_dbg), 32'(ST_IDLE));
  endtask

  // ---------------- time limit ----------------
  initial begin
    #200000;
    $display("FAIL timeout: got no finish, want finish within 200000 time units");
    $fatal(1, "bench timeout");
  end

  // ---------------- tests ----------------
  initial begin
    n_checks    = 0;
    n_pass      = 0;
    cyc         = 0;
    acc         = '0;
    rst         = 1'b1;
    bus.tf_full = 1'b0;
    drive_inputs();
    repeat (2) step();
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    // All four requesters valid: headers rotate A0..A3 then back to A0.
    wr_cyc.delete();
    for (int i = 0; i < N; i++) begin
      push_byte(i, 8'h10 + 8'(i), 1'b0);
      push_byte(i, 8'h20 + 8'(i), 1'b1);
    end
    push_byte(0, 8'h30, 1'b0);
    push_byte(0, 8'h31, 1'b1);
    for (int i = 0; i < N; i++) begin
      exp_q.push_back(8'hA0 + 8'(i));
      exp_q.push_back(8'h10 + 8'(i));
      exp_q.push_back(8'h20 + 8'(i));
    end
    exp_q.push_back(8'hA0);
    exp_q.push_back(8'h30);
    exp_q.push_back(8'h31);
    drive_inputs();
    t0 = cyc;
    run_drain("rr4_drain", 60);
    check("rr4_first_wr", 32'(wr_cyc[0]), 32'(t0 + 1));
    check("rr4_span", 32'(wr_cyc[wr_cyc.size()-1] - wr_cyc[0]), 32'd18);
    check("rr4_grant_idle", 32'(bus.grant), 32'd0);

    // Single requester: A0, 55, 0F back to back.
    wr_cyc.delete();
    push_byte(0, 8'h55, 1'b0);
    push_byte(0, 8'h0F, 1'b1);
    exp_q.push_back(8'hA0);
    exp_q.push_back(8'h55);
    exp_q.push_back(8'h0F);
    drive_inputs();
    t0 = cyc;
    step();
    check("single_grant", 32'(bus.grant), 32'h1);
    run_drain("single_drain", 20);
    check("single_wr0_cyc", 32'(wr_cyc[0]), 32'(t0 + 1));
    check("single_wr2_cyc", 32'(wr_cyc[2]), 32'(t0 + 3));
    check("single_grant_idle", 32'(bus.grant), 32'd0);

    // FIFO full for 5 cycles in the middle of req1's message.
    wr_cyc.delete();
    abort_cyc.delete();
    push_byte(1, 8'h41, 1'b0);
    push_byte(1, 8'h42, 1'b0);
    push_byte(1, 8'h43, 1'b1);
    exp_q.push_back(8'hA1);
    exp_q.push_back(8'h41);
    exp_q.push_back(8'h42);
    exp_q.push_back(8'h43);
    drive_inputs();
    t0 = cyc;
    step();
    step();
    bus.tf_full = 1'b1;
    repeat (5) step();
    bus.tf_full = 1'b0;
    run_drain("full_drain", 20);
    check("full_wr_count", 32'(wr_cyc.size()), 32'd4);
    check("full_resume_cyc", 32'(wr_cyc[1]), 32'(t0 + 7));
    check("full_last_cyc", 32'(wr_cyc[3]), 32'(t0 + 9));
    check("full_no_abort", 32'(abort_cyc.size()), 32'd0);

    // req2 stops mid-message; watchdog aborts, req3 is served next.
    wr_cyc.delete();
    abort_cyc.delete();
    push_byte(2, 8'h61, 1'b0);
    push_byte(2, 8'h62, 1'b0);
    push_byte(3, 8'h71, 1'b1);
    exp_q.push_back(8'hA2);
    exp_q.push_back(8'h61);
    exp_q.push_back(8'h62);
    exp_q.push_back(8'hA3);
    exp_q.push_back(8'h71);
    drive_inputs();
    t0 = cyc;
    run_drain("stall_drain", 40);
    check("stall_abort_count", 32'(abort_cyc.size()), 32'd1);
    if (abort_cyc.size() > 0) check("stall_abort_cyc", 32'(abort_cyc[0]), 32'(t0 + 7));
    check("stall_next_hdr_cyc", 32'(wr_cyc[3]), 32'(t0 + 9));
    check("stall_grant_idle", 32'(bus.grant), 32'd0);

    // Asynchronous reset between edges while req1 is streaming.
    push_byte(1, 8'h81, 1'b0);
    push_byte(1, 8'h82, 1'b0);
    push_byte(1, 8'h83, 1'b1);
    exp_q.push_back(8'hA1);
    drive_inputs();
    step();
    step();
    check("pre_rst_grant", 32'(bus.grant), 32'h2);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    rq[1].delete();
    drive_inputs();
    step();
    step();
    check("rst_drop", 32'(exp_q.size()), 32'd0);
    rst = 1'b0;
    wr_cyc.delete();
    push_byte(0, 8'h91, 1'b1);
    push_byte(3, 8'h93, 1'b1);
    exp_q.push_back(8'hA0);
    exp_q.push_back(8'h91);
    exp_q.push_back(8'hA3);
    exp_q.push_back(8'h93);
    drive_inputs();
    step();
    check("post_rst_grant", 32'(bus.grant), 32'h1);
    run_drain("post_rst_drain", 30);
    step();
    check("final_no_extra", 32'(wr_cyc.size()), 32'd4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
